// File: rtl/unary_stream_tx_if.sv
// Operand/stream bundle between a unary stream transmitter and whatever drives it.
// master = operand source (bench or datapath), slave = the transmitter.
interface unary_stream_tx_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] a_val;
    logic [CNT_W-1:0] b_val;
    logic             A;
    logic             B;
    logic             en;
    logic             read_or_write;
    logic             busy;
    logic             done;

    modport master (
        output start, a_val, b_val,
        input  A, B, en, read_or_write, busy, done
    );

    modport slave (
        input  start, a_val, b_val,
        output A, B, en, read_or_write, busy, done
    );
endinterface

// File: rtl/unary_stream_tx.sv
// Unary (thermometer) stream transmitter: sends two clamped operands as fixed-length frames, then a read-out window.
// Build option UNARY_TX_ALIGN_RIGHT_EN: right-aligned frames (zeros first) instead of ones first.
module unary_stream_tx #(
    parameter int CNT_W     = 4,
    parameter int FRAME_LEN = 15,
    parameter int RD_LEN    = 20
) (
    input logic              clk,
    input logic              rst,
    unary_stream_tx_if.slave bus
);
    localparam int KW = $clog2(FRAME_LEN + 1);
    localparam int RW = (RD_LEN > 1) ? $clog2(RD_LEN) : 1;

    localparam logic [CNT_W-1:0] OPND_MAX = CNT_W'(FRAME_LEN);
    localparam logic [KW-1:0]    K_FRAME  = KW'(FRAME_LEN);
    localparam logic [KW-1:0]    K_LAST   = KW'(FRAME_LEN - 1);
    localparam logic [RW-1:0]    RD_LAST  = RW'(RD_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        READOUT = 2'd2
    } state_t;

    // FRAME_LEN fits in CNT_W bits, so KW <= CNT_W and the slice is safe.
    function automatic logic [KW-1:0] sat_operand(input logic [CNT_W-1:0] v);
        if (v > OPND_MAX) return K_FRAME;
        return v[KW-1:0];
    endfunction

    function automatic logic frame_bit(input logic [KW-1:0] idx, input logic [KW-1:0] ones);
`ifdef UNARY_TX_ALIGN_RIGHT_EN
        return idx >= (K_FRAME - ones);
`else
        return idx < ones;
`endif
    endfunction

    state_t        state, state_n;
    logic [KW-1:0] k, k_n;
    logic [RW-1:0] rd_cnt, rd_n;
    logic [KW-1:0] a_q, a_n;
    logic [KW-1:0] b_q, b_n;

    logic a_bit, a_bit_n;
    logic b_bit, b_bit_n;
    logic en_q, en_n;
    logic rw_q, rw_n;
    logic busy_q, busy_n;
    logic done_q, done_n;

    always_comb begin
        state_n = state;
        k_n     = k;
        rd_n    = rd_cnt;
        a_n     = a_q;
        b_n     = b_q;
        done_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = SEND;
                    k_n     = '0;
                    a_n     = sat_operand(bus.a_val);
                    b_n     = sat_operand(bus.b_val);
                end
            end
            SEND: begin
                // Terminal compare before increment keeps k from wrapping.
                if (k == K_LAST) begin
                    state_n = READOUT;
                    rd_n    = '0;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            READOUT: begin
                if (rd_cnt == RD_LAST) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    rd_n = rd_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered without extra latency.
        en_n    = (state_n != IDLE);
        busy_n  = (state_n != IDLE);
        rw_n    = (state_n == READOUT);
        a_bit_n = (state_n == SEND) && frame_bit(k_n, a_n);
        b_bit_n = (state_n == SEND) && frame_bit(k_n, b_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            rd_cnt <= '0;
            a_q    <= '0;
            b_q    <= '0;
            a_bit  <= 1'b0;
            b_bit  <= 1'b0;
            en_q   <= 1'b0;
            rw_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            k      <= k_n;
            rd_cnt <= rd_n;
            a_q    <= a_n;
            b_q    <= b_n;
            a_bit  <= a_bit_n;
            b_bit  <= b_bit_n;
            en_q   <= en_n;
            rw_q   <= rw_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    assign bus.A             = a_bit;
    assign bus.B             = b_bit;
    assign bus.en            = en_q;
    assign bus.read_or_write = rw_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_unary_stream_tx.sv
// Bench for unary_stream_tx: transfer-schedule reference model checked every cycle, plus directed literal checks.
module tb_unary_stream_tx;
    localparam int CNT_W     = 4;
    localparam int FRAME_LEN = 15;
    localparam int RD_LEN    = 20;
    localparam int XFER      = FRAME_LEN + RD_LEN;

`ifdef UNARY_TX_ALIGN_RIGHT_EN
    localparam logic [14:0] EXP3 = 15'b000000000000111;
    localparam logic [14:0] EXP2 = 15'b000000000000011;
`else
    localparam logic [14:0] EXP3 = 15'b111000000000000;
    localparam logic [14:0] EXP2 = 15'b110000000000000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    unary_stream_tx_if #(.CNT_W(CNT_W)) bus ();

    unary_stream_tx #(
        .CNT_W    (CNT_W),
        .FRAME_LEN(FRAME_LEN),
        .RD_LEN   (RD_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a transfer is just "launch edge + operands"; the outputs in any
    // cycle follow from the offset since that launch.
    int edge_n = 0;
    int launch = -1;
    int ma     = 0;
    int mb     = 0;
    bit chk_on = 1'b0;

    function automatic int clampv(input int v);
        return (v > FRAME_LEN) ? FRAME_LEN : v;
    endfunction

    function automatic logic frame_ref(input int idx, input int ones);
`ifdef UNARY_TX_ALIGN_RIGHT_EN
        return idx >= FRAME_LEN - ones;
`else
        return idx < ones;
`endif
    endfunction

    // Packing: {A, B, en, read_or_write, busy, done}
    function automatic logic [5:0] expect_out(input int l, input int off, input int oa, input int ob);
        if (l < 0 || off > XFER) return 6'b000000;
        if (off < FRAME_LEN) return {frame_ref(off, oa), frame_ref(off, ob), 4'b1010};
        if (off < XFER) return 6'b001110;
        return 6'b000001;
    endfunction

    always @(posedge clk) begin
        int off_prev;
        off_prev = edge_n - launch;
        edge_n++;
        if (rst) begin
            launch = -1;
        end else if (bus.start && (launch < 0 || off_prev > XFER - 1)) begin
            launch = edge_n;
            ma     = clampv(int'(bus.a_val));
            mb     = clampv(int'(bus.b_val));
        end
        chk_on = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_on)
            check("cycle_outputs",
                  32'({bus.A, bus.B, bus.en, bus.read_or_write, bus.busy, bus.done}),
                  32'(expect_out(launch, edge_n - launch, ma, mb)));
    end

    bit cap_a    [0:127];
    bit cap_b    [0:127];
    bit cap_en   [0:127];
    bit cap_done [0:127];

    task automatic capture(input int ncyc, input int inj_at, input int rst_at);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            cap_a[i]    = bus.A;
            cap_b[i]    = bus.B;
            cap_en[i]   = bus.en;
            cap_done[i] = bus.done;
            if (i == inj_at) begin
                bus.start = 1'b1;
                bus.a_val = CNT_W'(1);
                bus.b_val = CNT_W'(1);
            end
            if (i == inj_at + 1) bus.start = 1'b0;
            if (i == rst_at) rst = 1'b1;
            if (i == rst_at + 1) rst = 1'b0;
        end
    endtask

    function automatic logic [14:0] frame(input int sel, input int from);
        logic [14:0] v;
        for (int i = 0; i < 15; i++) v[14-i] = (sel == 0) ? cap_a[from+i] : cap_b[from+i];
        return v;
    endfunction

    function automatic int cnt(input int sel, input int from, input int n);
        int c;
        c = 0;
        for (int i = from; i < from + n; i++)
            c += (sel == 0) ? int'(cap_a[i]) : (sel == 1) ? int'(cap_b[i]) :
                 (sel == 2) ? int'(cap_en[i]) : int'(cap_done[i]);
        return c;
    endfunction

    function automatic int first_done(input int n);
        for (int i = 0; i < n; i++) if (cap_done[i]) return i;
        return -1;
    endfunction

    task automatic launch_tx(input int a, input int b);
        @(posedge clk);
        #1;
        bus.a_val = CNT_W'(a);
        bus.b_val = CNT_W'(b);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a_val = '0;
        bus.b_val = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({bus.A, bus.B, bus.en, bus.read_or_write, bus.busy, bus.done}), 32'd0);
        rst = 1'b0;

        launch_tx(3, 3);
        capture(40, -10, -10);
        check("t1_frame_A", 32'(frame(0, 0)), 32'(EXP3));
        check("t1_frame_B", 32'(frame(1, 0)), 32'(EXP3));
        check("t1_done_offset", 32'(first_done(40)), 32'd35);
        check("t1_en_cycles", 32'(cnt(2, 0, 40)), 32'd35);
        check("t1_done_count", 32'(cnt(3, 0, 40)), 32'd1);

        launch_tx(15, 0);
        capture(40, -10, -10);
        check("t2_frame_A", 32'(frame(0, 0)), 32'h7fff);
        check("t2_frame_B", 32'(frame(1, 0)), 32'h0);
        check("t2_en_cycles", 32'(cnt(2, 0, 40)), 32'd35);

        launch_tx(7, 5);
        capture(80, 5, -10);
        check("t3_ones_A", 32'(cnt(0, 0, 15)), 32'd7);
        check("t3_ones_B", 32'(cnt(1, 0, 15)), 32'd5);
        check("t3_done_count", 32'(cnt(3, 0, 80)), 32'd1);

        launch_tx(9, 9);
        capture(40, -10, 6);
        check("t4_bit6_before_rst", 32'(cap_a[6]), 32'd1);
        check("t4_en_after_rst", 32'(cap_en[7]), 32'd0);
        check("t4_done_count", 32'(cnt(3, 0, 40)), 32'd0);
        launch_tx(2, 2);
        capture(40, -10, -10);
        check("t4_fresh_frame_A", 32'(frame(0, 0)), 32'(EXP2));

        @(posedge clk);
        #1;
        bus.a_val = CNT_W'(1);
        bus.b_val = CNT_W'(2);
        bus.start = 1'b1;
        capture(110, -10, -10);
        bus.start = 1'b0;
        check("t5_first_done", 32'(first_done(110)), 32'd36);
        check("t5_done_count", 32'(cnt(3, 0, 110)), 32'd3);
        check("t5_second_done", 32'(cap_done[72]), 32'd1);
        check("t5_relaunch_busy", 32'(cap_en[37]), 32'd1);
        check("t5_ones_A", 32'(cnt(0, 37, 15)), 32'd1);
        check("t5_ones_B", 32'(cnt(1, 37, 15)), 32'd2);

        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            bus.start = ($urandom_range(0, 3) == 0);
            bus.a_val = CNT_W'($urandom_range(0, 15));
            bus.b_val = CNT_W'($urandom_range(0, 15));
            rst       = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
